// File: rtl/dmem_dbg_if.sv
// Bus between the CPU/debug consumer side (master) and the data memory (slave).
interface dmem_dbg_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 8
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              mem_ready;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;

    modport master (
        output we, addr, din, dump_start, dump_ready,
        input  dout, mem_ready, dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );

    modport slave (
        input  we, addr, din, dump_start, dump_ready,
        output dout, mem_ready, dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );
endinterface

// File: rtl/dmem_dbg.sv
// Data memory with a combinational CPU read port, synchronous CPU write port,
// a power-on clear sequencer and a valid/ready dump engine for an address window.
module dmem_dbg #(
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int DUMP_BASE = 0,
    parameter int DUMP_LEN  = 19
) (
    input logic        clk,
    input logic        rst,
    dmem_dbg_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] CNT0 = ADDR_W'(DUMP_LEN - 1);

    typedef enum logic [1:0] {INIT, IDLE, DUMP} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] cnt;
    logic              mem_ready, dump_busy, dump_valid, dump_done;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              in_range;
    logic [ADDR_W-1:0] next_addr;

    // Extra MSB keeps the compare meaningful when DEPTH == 2**ADDR_W.
    assign in_range  = ({1'b0, bus.addr} < (ADDR_W + 1)'(DEPTH));
    // Dump window walks modulo DEPTH, which need not be a power of two.
    assign next_addr = (dump_addr == LAST) ? '0 : dump_addr + 1'b1;

    // Combinational CPU read; out-of-range addresses read as zero.
    assign bus.dout = in_range ? mem[bus.addr] : '0;

    // Array writes: clear sequencer owns the array in INIT, CPU afterwards.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[clr_ptr] <= '0;
        else if (bus.we && in_range)
            mem[bus.addr] <= bus.din;
    end

    // Control FSM with registered outputs. Dump loads read the pre-edge array,
    // so a same-edge CPU write to the loaded address is not seen by the dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            clr_ptr    <= '0;
            cnt        <= '0;
            mem_ready  <= 1'b0;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                INIT: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST) begin
                        state     <= IDLE;
                        mem_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.dump_start) begin
                        state      <= DUMP;
                        dump_busy  <= 1'b1;
                        dump_valid <= 1'b1;
                        dump_addr  <= BASE;
                        dump_data  <= mem[BASE];
                        cnt        <= CNT0;
                    end
                end
                DUMP: begin
                    if (dump_valid && bus.dump_ready) begin
                        if (cnt == '0) begin
                            state      <= IDLE;
                            dump_busy  <= 1'b0;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_addr <= next_addr;
                            dump_data <= mem[next_addr];
                            cnt       <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.mem_ready  = mem_ready;
    assign bus.dump_busy  = dump_busy;
    assign bus.dump_valid = dump_valid;
    assign bus.dump_addr  = dump_addr;
    assign bus.dump_data  = dump_data;
    assign bus.dump_done  = dump_done;
endmodule

// File: tb/tb_dmem_dbg.sv
// Directed bench: u0 is the default configuration (DEPTH 256, window 0..18),
// u1 uses DEPTH 200 with a window 195..4 that wraps through a non-power-of-two size.
module tb_dmem_dbg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_dbg_if #(.DATA_W(24), .ADDR_W(8)) b0 ();
    dmem_dbg_if #(.DATA_W(24), .ADDR_W(8)) b1 ();

    dmem_dbg #(.DATA_W(24), .ADDR_W(8), .DEPTH(256), .DUMP_BASE(0), .DUMP_LEN(19))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    dmem_dbg #(.DATA_W(24), .ADDR_W(8), .DEPTH(200), .DUMP_BASE(195), .DUMP_LEN(10))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r0, r1, idx, nz, guard;
        logic rdy;
        b0.we = 0; b0.addr = '0; b0.din = '0; b0.dump_start = 0; b0.dump_ready = 0;
        b1.we = 0; b1.addr = '0; b1.din = '0; b1.dump_start = 0; b1.dump_ready = 0;
        tick(); tick();

        // Reset state
        chk("rst_ready",  32'(b0.mem_ready),  0);
        chk("rst_valid",  32'(b0.dump_valid), 0);
        chk("rst_busy",   32'(b0.dump_busy),  0);
        chk("rst_done",   32'(b0.dump_done),  0);
        chk("rst_daddr",  32'(b0.dump_addr),  0);
        chk("rst_ddata",  32'(b0.dump_data),  0);

        // Clear sequence with a CPU write attempted throughout INIT
        rst = 0;
        b0.we = 1; b0.addr = 8'd5; b0.din = 24'hABCDEF;
        b0.dump_start = 1;
        r0 = 0; r1 = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (b0.mem_ready && r0 == 0) r0 = i;
            if (b1.mem_ready && r1 == 0) r1 = i;
            if (r0 != 0) begin
                b0.we = 0; b0.dump_start = 0;
            end
            if (r0 != 0 && r1 != 0) break;
        end
        chk("clear_cycles_256", 32'(r0), 256);
        chk("clear_cycles_200", 32'(r1), 200);
        chk("init_start_ignored", 32'(b0.dump_valid), 0);
        #1;
        chk("init_write_dropped", 32'(b0.dout), 0);

        // Write/read
        b0.we = 1; b0.addr = 8'd18; b0.din = 24'h123456;
        tick();
        b0.we = 0;
        chk("rd_addr18", 32'(b0.dout), 32'h123456);
        b0.we = 1; b0.addr = 8'd255; b0.din = 24'hFEDCBA;
        tick();
        b0.we = 0;
        chk("rd_addr255", 32'(b0.dout), 32'hFEDCBA);
        b1.we = 1; b1.addr = 8'd210; b1.din = 24'h555555;
        tick();
        b1.we = 0;
        chk("oor_dout", 32'(b1.dout), 0);
        b1.addr = 8'd10; #1;
        chk("oor_alias10", 32'(b1.dout), 0);
        b1.addr = 8'd82; #1;
        chk("oor_alias82", 32'(b1.dout), 0);
        b1.we = 1; b1.addr = 8'd199; b1.din = 24'h0000C7;
        tick();
        b1.we = 0;
        chk("rd_last_200", 32'(b1.dout), 32'hC7);

        // Full dump, ready tied high
        for (int i = 0; i < 19; i++) begin
            b0.we = 1; b0.addr = 8'(i); b0.din = 24'(i + 1);
            tick();
        end
        b0.we = 0;
        b0.dump_ready = 1; b0.dump_start = 1;
        tick();
        b0.dump_start = 0;
        for (int b = 0; b < 19; b++) begin
            chk("full_valid", 32'(b0.dump_valid), 1);
            chk("full_busy",  32'(b0.dump_busy),  1);
            chk("full_addr",  32'(b0.dump_addr),  32'(b));
            chk("full_data",  32'(b0.dump_data),  32'(b + 1));
            chk("full_done_low", 32'(b0.dump_done), 0);
            tick();
        end
        chk("full_end_valid", 32'(b0.dump_valid), 0);
        chk("full_end_busy",  32'(b0.dump_busy),  0);
        chk("full_end_done",  32'(b0.dump_done),  1);
        tick();
        chk("full_done_pulse", 32'(b0.dump_done), 0);

        // Backpressure with random ready and stray dump_start during DUMP
        b0.dump_ready = 0; b0.dump_start = 1;
        tick();
        idx = 0; guard = 0;
        while (b0.dump_valid && guard < 400) begin
            rdy = 1'($urandom_range(0, 1));
            b0.dump_ready = rdy;
            b0.dump_start = 1'($urandom_range(0, 1));
            chk("bp_addr", 32'(b0.dump_addr), 32'(idx));
            chk("bp_data", 32'(b0.dump_data), 32'(idx + 1));
            tick();
            if (rdy) idx++;
            guard++;
        end
        b0.dump_start = 0; b0.dump_ready = 1;
        chk("bp_count", 32'(idx), 19);
        chk("bp_done",  32'(b0.dump_done), 1);
        tick();
        chk("bp_no_requeue", 32'(b0.dump_valid), 0);

        // Wrap and collision on u1: window 195..199,0..4
        for (int k = 0; k < 10; k++) begin
            b1.we = 1; b1.addr = 8'((195 + k) % 200); b1.din = 24'(((195 + k) % 200) + 256);
            tick();
        end
        b1.we = 0;
        b1.dump_ready = 1; b1.dump_start = 1;
        tick();
        b1.dump_start = 0;
        for (int k = 0; k < 10; k++) begin
            chk("wrap_addr", 32'(b1.dump_addr), 32'((195 + k) % 200));
            chk("wrap_data", 32'(b1.dump_data), 32'(((195 + k) % 200) + 256));
            if (k == 1) begin
                b1.we = 1; b1.addr = 8'd197; b1.din = 24'h777777;
            end
            tick();
            b1.we = 0;
            if (k == 1) chk("coll_dout_new", 32'(b1.dout), 32'h777777);
        end
        chk("wrap_done", 32'(b1.dump_done), 1);
        b1.addr = 8'd197; #1;
        chk("coll_mem_kept", 32'(b1.dout), 32'h777777);

        // Reset mid-dump at beat 7
        b0.dump_ready = 1; b0.dump_start = 1;
        tick();
        b0.dump_start = 0;
        for (int k = 0; k < 7; k++) tick();
        chk("pre_rst_addr", 32'(b0.dump_addr), 7);
        rst = 1; #1;
        chk("mid_rst_valid", 32'(b0.dump_valid), 0);
        chk("mid_rst_busy",  32'(b0.dump_busy),  0);
        chk("mid_rst_ready", 32'(b0.mem_ready),  0);
        chk("mid_rst_daddr", 32'(b0.dump_addr),  0);
        chk("mid_rst_ddata", 32'(b0.dump_data),  0);
        tick();
        rst = 0;
        r0 = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (b0.mem_ready) begin
                r0 = i;
                break;
            end
        end
        chk("reclear_cycles", 32'(r0), 256);
        nz = 0;
        for (int a = 0; a < 256; a++) begin
            b0.addr = 8'(a); #1;
            if (b0.dout !== 24'h0) nz++;
        end
        chk("reclear_all_zero", 32'(nz), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
